// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 responder: oversampled SCLK/MOSI/CS_N, one transmit buffer, strobed receive byte.
// Optional ERR output (underrun / aborted frame) is built when SPI_SLAVE_ERR_EN is defined.
module spi_slave_rx_tx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       T_STB,
    input  logic [7:0] T_DATA,
    output logic       T_READY,
    output logic       R_STB,
    output logic [7:0] R_DATA,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       CS_N,
    output logic       MISO
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic       ERR
`endif
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_d, cs_d;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    state_t     state_q, state_d;
    logic       rise_en, fall_en, commit;
    logic [7:0] buf_data, load_byte;
    logic       buf_full;
    logic [6:0] tx_shift;
    logic       tx_from_buf;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync <= '0;
            mosi_sync <= '1;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise)      state_d = ST_IDLE;
        else if (cs_fall) state_d = ST_ACTIVE;
    end

    always_comb begin
        rise_en = 1'b0;
        fall_en = 1'b0;
        if (state_q == ST_ACTIVE && !cs_rise) begin
            rise_en = sclk_rise;
            fall_en = sclk_fall;
        end
    end

    assign load_byte = buf_full ? buf_data : IDLE_BYTE;
    // The first rise of a byte slot is where the loaded byte is committed.
    assign commit    = rise_en && (bit_cnt == 3'd0);
    assign T_READY   = ~buf_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_data    <= '0;
            buf_full    <= 1'b0;
            tx_shift    <= IDLE_BYTE[6:0];
            tx_from_buf <= 1'b0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            R_DATA      <= '0;
            R_STB       <= 1'b0;
            MISO        <= 1'b1;
        end else begin
            R_STB <= 1'b0;
            if (cs_rise) begin
                bit_cnt <= '0;
                MISO    <= 1'b1;
            end else if (cs_fall) begin
                bit_cnt     <= '0;
                tx_shift    <= load_byte[6:0];
                tx_from_buf <= buf_full;
                MISO        <= load_byte[7];
            end else begin
                if (rise_en) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        R_DATA <= {rx_shift, mosi_s};
                        R_STB  <= 1'b1;
                    end
                end
                if (fall_en) begin
                    if (bit_cnt != 3'd0) begin
                        tx_shift <= {tx_shift[5:0], 1'b0};
                        MISO     <= tx_shift[6];
                    end else begin
                        // Byte boundary: peek the buffer without consuming it.
                        tx_shift    <= load_byte[6:0];
                        tx_from_buf <= buf_full;
                        MISO        <= load_byte[7];
                    end
                end
            end
            if (commit && tx_from_buf) begin
                buf_full <= 1'b0;
            end else if (T_STB && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= T_DATA;
            end
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ERR <= 1'b0;
        else        ERR <= (commit && !tx_from_buf) || (cs_rise && bit_cnt != 3'd0);
    end
`endif

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: bench acts as SPI master, scoreboard checks received bytes.
module tb_spi_slave_rx_tx;

    localparam int HALF = 6;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       T_STB;
    logic [7:0] T_DATA;
    logic       T_READY;
    logic       R_STB;
    logic [7:0] R_DATA;
    logic       SCLK;
    logic       MOSI;
    logic       CS_N;
    logic       MISO;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic [7:0] s1, s2;

`ifdef SPI_SLAVE_ERR_EN
    logic err;
    int   err_cnt = 0;
`endif

    spi_slave_rx_tx #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .T_STB(T_STB),
        .T_DATA(T_DATA),
        .T_READY(T_READY),
        .R_STB(R_STB),
        .R_DATA(R_DATA),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .CS_N(CS_N),
        .MISO(MISO)
`ifdef SPI_SLAVE_ERR_EN
        ,
        .ERR(err)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_tx(input logic [7:0] d);
        T_DATA = d;
        T_STB  = 1'b1;
        wait_clks(1);
        T_STB  = 1'b0;
    endtask

    task automatic cs_low();
        CS_N = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_high();
        wait_clks(HALF);
        CS_N = 1'b1;
        wait_clks(HALF);
    endtask

    // Master side: MOSI set while SCLK low, MISO sampled at the rising edge.
    task automatic xfer_bits(input logic [7:0] m, input int hi, input int lo, output logic [7:0] s);
        s = '0;
        for (int i = hi; i >= lo; i--) begin
            MOSI = m[i];
            wait_clks(HALF);
            SCLK = 1'b1;
            s[i] = MISO;
            wait_clks(HALF);
            SCLK = 1'b0;
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && R_STB) begin
            if (exp_q.size() == 0) begin
                check("r_stb_extra", 32'(R_STB), 32'd0);
            end else begin
                exp_b = exp_q.pop_front();
                check("r_data", 32'(R_DATA), 32'(exp_b));
            end
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    always @(negedge CLK) if (err) err_cnt++;
`endif

    initial begin
        RST_N = 1'b0; SCLK = 1'b0; MOSI = 1'b1; CS_N = 1'b1; T_STB = 1'b0; T_DATA = '0;
        wait_clks(3);
        check("rst_t_ready", 32'(T_READY), 32'd1);
        check("rst_r_stb", 32'(R_STB), 32'd0);
        check("rst_r_data", 32'(R_DATA), 32'd0);
        check("rst_miso", 32'(MISO), 32'd1);
        RST_N = 1'b1;
        wait_clks(3);

        // Buffered byte returned while master sends 3C
        load_tx(8'hA5);
        check("t1_t_ready_loaded", 32'(T_READY), 32'd0);
        exp_q.push_back(8'h3C);
        cs_low();
        check("t1_t_ready_pre_rise", 32'(T_READY), 32'd0);
        xfer_bits(8'h3C, 7, 7, s1);
        check("t1_t_ready_post_rise", 32'(T_READY), 32'd1);
        xfer_bits(8'h3C, 6, 0, s2);
        check("t1_miso", 32'(s1 | s2), 32'h A5);
        cs_high();
`ifdef SPI_SLAVE_ERR_EN
        check("t1_err", 32'(err_cnt), 32'd0);
`endif

        // Empty buffer: idle byte returned (underrun)
        exp_q.push_back(8'h00);
        cs_low();
        xfer_bits(8'h00, 7, 0, s1);
        check("t2_miso", 32'(s1), 32'hFF);
        cs_high();
`ifdef SPI_SLAVE_ERR_EN
        check("t2_err", 32'(err_cnt), 32'd1);
`endif

        // Two-byte frame, second byte loaded mid-way through the first
        load_tx(8'h11);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        cs_low();
        fork
            xfer_bits(8'h81, 7, 0, s1);
            begin
                wait_clks(30);
                load_tx(8'h22);
            end
        join
        check("t3_miso_b0", 32'(s1), 32'h11);
        xfer_bits(8'h7E, 7, 0, s2);
        check("t3_miso_b1", 32'(s2), 32'h22);
        cs_high();
        check("t3_t_ready", 32'(T_READY), 32'd1);

        // Aborted frame after 5 bits, then a clean frame
        cs_low();
        xfer_bits(8'hAA, 7, 3, s1);
        check("t4_miso_partial", 32'(s1), 32'hF8);
        cs_high();
`ifdef SPI_SLAVE_ERR_EN
        check("t4_err_abort", 32'(err_cnt), 32'd3);
`endif
        exp_q.push_back(8'hC3);
        cs_low();
        xfer_bits(8'hC3, 7, 0, s1);
        cs_high();
        check("t4_miso", 32'(s1), 32'hFF);
`ifdef SPI_SLAVE_ERR_EN
        check("t4_err", 32'(err_cnt), 32'd4);
`endif

        // Load while full is ignored
        load_tx(8'h99);
        check("t5_t_ready_full", 32'(T_READY), 32'd0);
        load_tx(8'h55);
        check("t5_t_ready_still", 32'(T_READY), 32'd0);
        exp_q.push_back(8'h5A);
        cs_low();
        xfer_bits(8'h5A, 7, 0, s1);
        check("t5_miso", 32'(s1), 32'h99);
        cs_high();
        check("t5_t_ready_empty", 32'(T_READY), 32'd1);
`ifdef SPI_SLAVE_ERR_EN
        check("t5_err", 32'(err_cnt), 32'd4);
`endif

        // Reset mid-transfer drops everything, including the buffer
        cs_low();
        xfer_bits(8'h3F, 7, 4, s1);
        load_tx(8'h5A);
        check("t6_t_ready_pre", 32'(T_READY), 32'd0);
        RST_N = 1'b0;
        #1;
        check("t6_t_ready", 32'(T_READY), 32'd1);
        check("t6_r_stb", 32'(R_STB), 32'd0);
        check("t6_r_data", 32'(R_DATA), 32'd0);
        check("t6_miso", 32'(MISO), 32'd1);
        CS_N = 1'b1;
        wait_clks(3);
        RST_N = 1'b1;
        wait_clks(3);
        exp_q.push_back(8'hE7);
        cs_low();
        xfer_bits(8'hE7, 7, 0, s1);
        cs_high();
        check("t6_miso_after", 32'(s1), 32'hFF);
`ifdef SPI_SLAVE_ERR_EN
        check("t6_err", 32'(err_cnt), 32'd6);
`endif

        wait_clks(10);
        check("r_stb_missing", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
